// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-port memory between the CPU and a DMA/IO
// requester. Grants one command per cycle, round-robin on contention, holds a
// CPU lock across ISZ read-modify-write, and routes read data back to the
// requester that issued the read.
module mem_arbiter #(
    parameter int DWIDTH     = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic                  cpu_lock,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0]     cpu_wdata,
    output logic                  cpu_ack,
    output logic                  cpu_rvalid,
    output logic [DWIDTH-1:0]     cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DWIDTH-1:0]     dma_wdata,
    output logic                  dma_ack,
    output logic                  dma_rvalid,
    output logic [DWIDTH-1:0]     dma_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0]     mem_wdata,
    input  logic [DWIDTH-1:0]     mem_rdata,
    output logic                  owner,
    output logic                  locked
);

    typedef enum logic {ARB, LOCK} state_t;

    state_t              state_q;
    logic                last_q;      // 0 = CPU granted last, 1 = DMA
    logic                owner_q;
    logic                locked_q;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0]   own_pipe_q, own_pipe_d;
    logic [DWIDTH-1:0]   cpu_rdata_q, dma_rdata_q;

    logic cpu_gnt, dma_gnt, rd_go, emerge;

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (state_q == LOCK) begin
                cpu_gnt = cpu_req;
            end else if (cpu_req && dma_req) begin
                cpu_gnt = last_q;
                dma_gnt = !last_q;
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    // Command path: winner's fields go straight to memory in the grant cycle
    always_comb begin
        mem_en    = cpu_gnt | dma_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_ack = cpu_gnt;
    assign dma_ack = dma_gnt;
    assign rd_go   = (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);

    // Read-return shift register: stage 0 loads on an acked read
    always_comb begin
        vld_pipe_d    = '0;
        own_pipe_d    = '0;
        vld_pipe_d[0] = rd_go;
        own_pipe_d[0] = dma_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            own_pipe_d[i] = own_pipe_q[i-1];
        end
    end

    assign emerge     = vld_pipe_q[RD_LAT-1] && !reset;
    assign cpu_rvalid = emerge && !own_pipe_q[RD_LAT-1];
    assign dma_rvalid = emerge &&  own_pipe_q[RD_LAT-1];
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;
    assign owner      = owner_q;
    assign locked     = locked_q;

    // Arbitration FSM with lock handling, grant history and registered status
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            if (cpu_gnt) begin
                last_q  <= 1'b0;
                owner_q <= 1'b0;
            end else if (dma_gnt) begin
                last_q  <= 1'b1;
                owner_q <= 1'b1;
            end
            case (state_q)
                ARB: begin
                    if (cpu_gnt && !cpu_we && cpu_lock) begin
                        state_q  <= LOCK;
                        locked_q <= 1'b1;
                    end
                end
                LOCK: begin
                    // Leave after the unlocked write-back, or if the CPU drops the lock idle
                    if ((cpu_gnt && !cpu_lock) || (!cpu_req && !cpu_lock)) begin
                        state_q  <= ARB;
                        locked_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ARB;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline and held read data; reset discards reads in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            own_pipe_q  <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            own_pipe_q <= own_pipe_d;
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

endmodule
